// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the single-port SRAM request controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 7;
  localparam int SRAM_DATA_W = 36;
  localparam int RESP_DEPTH  = 2;
  localparam int OCC_W       = $clog2(RESP_DEPTH + 1);

  // Which requester owns the RW port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry response buffer. The head drives the output; an empty buffer
// presents zero so stale or unknown storage never leaks out.
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] mem [RESP_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              pop_eff;

  // A pop on an empty buffer is ignored.
  assign pop_eff   = pop && (occ != '0);
  assign head_data = (occ != '0) ? mem[rd_ptr] : '0;

  // Storage, pointers and occupancy; push and pop may coincide at any level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_eff) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop_eff})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/sram_1rw_port_ctrl.sv
// Request-side controller for a single-port 1RW SRAM macro. Arbitrates write
// and read request streams onto the RW port and returns read data through a
// two-entry response buffer sized so a stalled consumer never loses data.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Requesters hold valid and payload stable until accepted;
// ready here may depend combinationally on valid (and rd_ready on resp_ready).
module sram_1rw_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  grant_e           gnt;
  logic             prio_rd;
  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic [2:0]       credit;
  logic             rd_elig;
  logic             contested;

  assign pop        = resp_valid && resp_ready;
  assign resp_valid = (occ != '0);

  // A read may issue only if its data is guaranteed a buffer slot; counting
  // this cycle's pop lets throughput stay at one read per cycle.
  assign credit  = 3'(occ) + 3'(inflight);
  assign rd_elig = credit < (3'(RESP_DEPTH) + 3'(pop));

  assign contested = !reset && wr_valid && rd_valid && rd_elig;

  // Grant selection: round-robin when both compete, otherwise whoever asks.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (contested) begin
        gnt = prio_rd ? GNT_RD : GNT_WR;
      end else if (wr_valid) begin
        gnt = GNT_WR;
      end else if (rd_valid && rd_elig) begin
        gnt = GNT_RD;
      end
    end
  end

  assign wr_ready = (gnt == GNT_WR);
  assign rd_ready = (gnt == GNT_RD);

  // Port drive follows the grant in the same cycle; idle cycles drive zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt)
      GNT_WR: begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
      GNT_RD: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
      default: ;
    endcase
  end

  // Track the outstanding read and rotate priority after contested grants.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      prio_rd  <= 1'b1;
    end else begin
      inflight <= rd_ready;
      if (contested) begin
        prio_rd <= ~prio_rd;
      end
    end
  end

  // Macro data is captured only in the cycle after a read grant.
  sram_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (mem_rdata),
    .pop       (pop),
    .head_data (resp_data),
    .occ       (occ)
  );

endmodule
